pc_sequencer: RTL

- Owns the program counter and sequences instruction fetch and execute around stalling instruction and data memories.
- Computes the next PC from the jump/branch controls decoded by the control unit: sequential, jump, branch-if-equal or branch-if-not-equal.
- Drives the instruction memory read request and tells the datapath when the fetched instruction is valid.
- Replaces the free-running PC register once cached memories with busywait are in the CPU.

---
 rtl/pc_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter and fetch/execute sequencer for stalling instruction and data memories.
// Optional performance counters are built when PC_SEQ_PERF_CNT_EN is defined.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hFFFFFFFC,
  parameter int          OFFSET_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_busywait,
  input  logic                data_busywait,
  input  logic                jump,
  input  logic                branch,
  input  logic                branch_ne,
  input  logic                zero,
  input  logic [OFFSET_W-1:0] offset,
  output logic [31:0]         pc,
  output logic                instr_read,
  output logic                instr_valid,
  output logic                branch_taken,
  output logic                stall,
  output logic [15:0]         stall_count,
  output logic [15:0]         retired_count
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        taken;
  logic [31:0] offset_bytes;
  logic [31:0] pc_plus4;
  logic        retire;

  assign taken        = jump | (branch & zero) | (branch_ne & ~zero);
  assign offset_bytes = {{(32-OFFSET_W-2){offset[OFFSET_W-1]}}, offset, 2'b00};
  assign pc_plus4     = pc_q + 32'd4;
  assign retire       = (state_q == EXEC) && !data_busywait;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_read   = 1'b0;
    instr_valid  = 1'b0;
    branch_taken = 1'b0;
    stall        = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        pc_d    = RESET_PC + 32'd4;
      end
      FETCH: begin
        instr_read = 1'b1;
        stall      = instr_busywait;
        if (!instr_busywait) state_d = EXEC;
      end
      EXEC: begin
        instr_valid  = 1'b1;
        branch_taken = taken;
        stall        = data_busywait;
        if (!data_busywait) begin
          state_d = FETCH;
          pc_d    = taken ? (pc_plus4 + offset_bytes) : pc_plus4;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign pc = pc_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, retired_cnt_q;

  // Both counters saturate rather than wrap so long runs never read as short ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF))    stall_cnt_q   <= stall_cnt_q + 16'd1;
      if (retire && (retired_cnt_q != 16'hFFFF)) retired_cnt_q <= retired_cnt_q + 16'd1;
    end
  end

  assign stall_count   = stall_cnt_q;
  assign retired_count = retired_cnt_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign stall_count   = '0;
  assign retired_count = '0;
`endif

endmodule
